// File: rtl/azimuth_pkg.sv
// Shared definitions for the azimuth pattern path.
// Provides the default stream word width, the loader state encoding and an
// elaboration-time helper that validates pattern / word geometry.
package azimuth_pkg;

    localparam int unsigned AZ_WORD_W = 32;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        FULL    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    // True when a pattern of 'size' bits splits into whole stream words.
    function automatic bit size_ok(input int unsigned size, input int unsigned word_w);
        return (word_w != 0) && (size >= word_w) && ((size % word_w) == 0);
    endfunction

endpackage

// File: rtl/azimuth_data_loader.sv
// Double-buffered azimuth pattern loader.
// Assembles a SIZE-bit pattern from a WORD_W-bit stream into a shadow
// register and swaps it into the active DATA register on a sweep trigger.
// Ports:
//   SYS_CLK, RESETN          clock, async active-low reset
//   EN                       block enable; low clears the fill and ignores TRIG
//   TRIG                     single-cycle sweep start
//   S_TDATA/TVALID/TREADY/TLAST  pattern stream in
//   DATA, DATA_VALID         active pattern to the generator
//   TRIG_OUT                 TRIG delayed one cycle, aligned with new DATA
//   LOADED                   shadow holds a complete pattern
//   UNDERRUN, FRAME_ERR      one-cycle error pulses
module azimuth_data_loader
    import azimuth_pkg::*;
#(
    parameter int unsigned SIZE   = 3200,
    parameter int unsigned WORD_W = AZ_WORD_W
) (
    input  logic              SYS_CLK,
    input  logic              RESETN,
    input  logic              EN,
    input  logic              TRIG,
    input  logic [WORD_W-1:0] S_TDATA,
    input  logic              S_TVALID,
    output logic              S_TREADY,
    input  logic              S_TLAST,
    output logic [SIZE-1:0]   DATA,
    output logic              DATA_VALID,
    output logic              TRIG_OUT,
    output logic              LOADED,
    output logic              UNDERRUN,
    output logic              FRAME_ERR
);

    localparam int unsigned WORDS = SIZE / WORD_W;
    localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

    // Geometry check at elaboration.
    if (!size_ok(SIZE, WORD_W)) begin : g_bad_geometry
        $error("azimuth_data_loader: SIZE must be a non-zero multiple of WORD_W");
    end

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [SIZE-1:0]  shadow;
    logic             accept;
    logic             shadow_we;
    logic             swap;
    logic             underrun_nxt;
    logic             frame_err_nxt;
    logic             loaded_nxt;

    // Ready depends only on registered state plus enable and reset.
    assign S_TREADY = EN && RESETN && (state != FULL);
    assign accept   = S_TVALID && S_TREADY;

    // Next-state, counter and pulse decode.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        shadow_we     = 1'b0;
        swap          = 1'b0;
        underrun_nxt  = 1'b0;
        frame_err_nxt = 1'b0;

        if (!EN) begin
            state_nxt = FILL;
            cnt_nxt   = '0;
        end else begin
            case (state)
                FILL: begin
                    // A trigger coinciding with the completing beat is still an underrun.
                    underrun_nxt = TRIG;
                    if (accept) begin
                        shadow_we = 1'b1;
                        if (cnt == CNT_LAST) begin
                            cnt_nxt = '0;
                            if (S_TLAST) begin
                                state_nxt = FULL;
                            end else begin
                                frame_err_nxt = 1'b1;
                                state_nxt     = DISCARD;
                            end
                        end else if (S_TLAST) begin
                            frame_err_nxt = 1'b1;
                            cnt_nxt       = '0;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                end
                DISCARD: begin
                    underrun_nxt = TRIG;
                    if (accept && S_TLAST) begin
                        state_nxt = FILL;
                    end
                end
                FULL: begin
                    if (TRIG) begin
                        swap      = 1'b1;
                        state_nxt = FILL;
                    end
                end
                default: begin
                    state_nxt = FILL;
                    cnt_nxt   = '0;
                end
            endcase
        end

        loaded_nxt = (state_nxt == FULL);
    end

    // Control and active-pattern registers.
    always_ff @(posedge SYS_CLK or negedge RESETN) begin
        if (!RESETN) begin
            state      <= FILL;
            cnt        <= '0;
            DATA       <= '0;
            DATA_VALID <= 1'b0;
            TRIG_OUT   <= 1'b0;
            LOADED     <= 1'b0;
            UNDERRUN   <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            TRIG_OUT  <= TRIG && EN;
            LOADED    <= loaded_nxt;
            UNDERRUN  <= underrun_nxt;
            FRAME_ERR <= frame_err_nxt;
            if (swap) begin
                DATA       <= shadow;
                DATA_VALID <= 1'b1;
            end
        end
    end

    // Shadow content is only meaningful once LOADED, so it needs no reset.
    always_ff @(posedge SYS_CLK) begin
        if (shadow_we) begin
            shadow[cnt*WORD_W +: WORD_W] <= S_TDATA;
        end
    end

endmodule

// File: tb/tb_azimuth_data_loader.sv
// Self-checking bench for azimuth_data_loader (SIZE=128, WORD_W=32).
module tb_azimuth_data_loader;

    localparam int unsigned SIZE   = 128;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned WORDS  = SIZE / WORD_W;

    logic              clk   = 1'b0;
    logic              rstn  = 1'b0;
    logic              en    = 1'b0;
    logic              trig  = 1'b0;
    logic [WORD_W-1:0] tdata = '0;
    logic              valid = 1'b0;
    logic              last  = 1'b0;
    logic              tready;
    logic [SIZE-1:0]   data;
    logic              data_valid;
    logic              trig_out;
    logic              loaded;
    logic              underrun;
    logic              frame_err;

    azimuth_data_loader #(.SIZE(SIZE), .WORD_W(WORD_W)) dut (
        .SYS_CLK   (clk),
        .RESETN    (rstn),
        .EN        (en),
        .TRIG      (trig),
        .S_TDATA   (tdata),
        .S_TVALID  (valid),
        .S_TREADY  (tready),
        .S_TLAST   (last),
        .DATA      (data),
        .DATA_VALID(data_valid),
        .TRIG_OUT  (trig_out),
        .LOADED    (loaded),
        .UNDERRUN  (underrun),
        .FRAME_ERR (frame_err)
    );

    always #5 clk = ~clk;

    // Reference model: words of the pattern being gathered, a completed pattern
    // waiting for its trigger, and the pattern currently shown.
    logic [WORD_W-1:0] m_words[$];
    bit                m_full, m_disc, m_dv, m_uf, m_fe, m_to;
    logic [SIZE-1:0]   m_shadow, m_data;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [SIZE-1:0] got, input logic [SIZE-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic void model_reset();
        m_words.delete();
        m_full = 0; m_disc = 0; m_dv = 0; m_uf = 0; m_fe = 0; m_to = 0;
        m_data = '0;
    endfunction

    // One clock edge of the model, using the input values present before the edge.
    function automatic void model_edge();
        bit ready;
        ready = en && !m_full;
        m_uf  = 0;
        m_fe  = 0;
        m_to  = trig && en;
        if (!en) begin
            m_words.delete();
            m_full = 0;
            m_disc = 0;
            return;
        end
        if (trig) begin
            if (m_full) begin
                m_data = m_shadow;
                m_dv   = 1;
                m_full = 0;
            end else begin
                m_uf = 1;
            end
        end
        if (valid && ready) begin
            if (m_disc) begin
                if (last) m_disc = 0;
            end else begin
                m_words.push_back(tdata);
                if (m_words.size() == WORDS) begin
                    if (last) begin
                        for (int i = 0; i < WORDS; i++) m_shadow[i*WORD_W +: WORD_W] = m_words[i];
                        m_full = 1;
                    end else begin
                        m_fe   = 1;
                        m_disc = 1;
                    end
                    m_words.delete();
                end else if (last) begin
                    m_fe = 1;
                    m_words.delete();
                end
            end
        end
    endfunction

    task automatic check_outs();
        check("data",       data,       m_data);
        check("data_valid", SIZE'(data_valid), SIZE'(m_dv));
        check("loaded",     SIZE'(loaded),     SIZE'(m_full));
        check("underrun",   SIZE'(underrun),   SIZE'(m_uf));
        check("frame_err",  SIZE'(frame_err),  SIZE'(m_fe));
        check("trig_out",   SIZE'(trig_out),   SIZE'(m_to));
    endtask

    // Inputs are set just after a rising edge; step checks ready, clocks, then checks outputs.
    task automatic step();
        #1;
        check("tready", SIZE'(tready), SIZE'(rstn && en && !m_full));
        @(posedge clk);
        if (rstn) model_edge();
        #1;
        check_outs();
    endtask

    task automatic send(input logic [WORD_W-1:0] w, input bit l);
        valid = 1'b1; tdata = w; last = l;
        step();
        valid = 1'b0; last = 1'b0;
    endtask

    task automatic fire_trig();
        trig = 1'b1;
        step();
        trig = 1'b0;
    endtask

    initial begin
        model_reset();

        // Reset held with the stream active.
        valid = 1'b1; tdata = 32'hdead_beef; en = 1'b1;
        repeat (3) step();
        check("rst_tready", SIZE'(tready), '0);
        check("rst_data",   data, '0);
        valid = 1'b0;
        rstn  = 1'b1;

        // Normal load and swap.
        send(32'h1, 0); send(32'h2, 0); send(32'h3, 0); send(32'h4, 1);
        check("loaded_before_trig", SIZE'(loaded), SIZE'(1));
        fire_trig();
        check("swap_data", data, 128'h00000004_00000003_00000002_00000001);
        check("swap_trig_out", SIZE'(trig_out), SIZE'(1));
        step();
        check("trig_out_one_cycle", SIZE'(trig_out), '0);

        // Backpressure: fifth word waits until the swap frees the shadow.
        send(32'ha1, 0); send(32'ha2, 0); send(32'ha3, 0); send(32'ha4, 1);
        valid = 1'b1; tdata = 32'h5; last = 1'b0;
        repeat (3) step();
        trig = 1'b1; step(); trig = 1'b0;
        step();
        valid = 1'b0;
        send(32'h6, 0); send(32'h7, 0); send(32'h8, 1);
        fire_trig();
        check("bp_word_lsb", SIZE'(data[31:0]), SIZE'(32'h5));

        // Underrun after two words, then completion and swap.
        send(32'h9, 0); send(32'ha, 0);
        fire_trig();
        check("underrun_pulse", SIZE'(underrun), SIZE'(1));
        send(32'hb, 0); send(32'hc, 1);
        fire_trig();
        check("post_underrun_data", data, 128'h0000000c_0000000b_0000000a_00000009);

        // Early TLAST, then a clean pattern from word 0.
        send(32'hd, 0); send(32'he, 1);
        check("early_tlast_fe", SIZE'(frame_err), SIZE'(1));
        send(32'h15, 0); send(32'h16, 0); send(32'h17, 0); send(32'h18, 1);
        fire_trig();
        check("after_early_tlast", data, 128'h00000018_00000017_00000016_00000015);

        // Missing TLAST: drop beats through the next TLAST.
        send(32'h21, 0); send(32'h22, 0); send(32'h23, 0); send(32'h24, 0);
        check("missing_tlast_fe", SIZE'(frame_err), SIZE'(1));
        send(32'h25, 0); send(32'h26, 0); send(32'h27, 1);
        check("discard_not_loaded", SIZE'(loaded), '0);
        send(32'h31, 0); send(32'h32, 0); send(32'h33, 0); send(32'h34, 1);
        fire_trig();

        // Async reset mid-fill.
        send(32'h41, 0); send(32'h42, 0); send(32'h43, 0);
        #2; rstn = 1'b0; #1;
        model_reset();
        check("async_rst_data", data, '0);
        check("async_rst_dv", SIZE'(data_valid), '0);
        check("async_rst_tready", SIZE'(tready), '0);
        @(posedge clk); #1;
        rstn = 1'b1;
        send(32'h51, 0); send(32'h52, 0); send(32'h53, 0); send(32'h54, 1);
        fire_trig();
        check("after_rst_data", data, 128'h00000054_00000053_00000052_00000051);

        // EN low mid-fill drops the partial pattern but holds DATA.
        send(32'h61, 0); send(32'h62, 0); send(32'h63, 0);
        en = 1'b0; trig = 1'b1; valid = 1'b1; tdata = 32'h64;
        repeat (2) step();
        check("en_low_tready", SIZE'(tready), '0);
        check("en_low_data_held", data, 128'h00000054_00000053_00000052_00000051);
        trig = 1'b0; valid = 1'b0; en = 1'b1;
        send(32'h71, 0); send(32'h72, 0); send(32'h73, 0); send(32'h74, 1);
        fire_trig();
        check("en_restart_data", data, 128'h00000074_00000073_00000072_00000071);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            en    = ($urandom % 32) != 0;
            trig  = ($urandom % 8) == 0;
            valid = ($urandom % 4) != 0;
            tdata = $urandom;
            if (m_words.size() == WORDS - 1) last = ($urandom % 8) != 0;
            else                             last = ($urandom % 12) == 0;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/azimuth_data_loader.md
# azimuth_data_loader

Double-buffered loader that assembles one azimuth sweep pattern (SIZE bits) from a 32-bit stream coming out of the DMA FIFO. It presents a stable active pattern on DATA to `azimuth_signal_generator`. It refills a shadow copy in the background and swaps shadow to active only at a sweep trigger. It sits directly upstream of `azimuth_signal_generator`. Its DATA and TRIG_OUT drive that block's DATA and TRIG.

## Interface
Parameters:
- SIZE, 3200, pattern length in bits; must be a multiple of WORD_W.
- WORD_W, 32, stream word width; WORDS = SIZE/WORD_W (100 by default).

Ports:
- SYS_CLK  in  1  system clock (100 MHz); the only clock.
- RESETN  in  1  asynchronous, active-low reset.
- EN  in  1  block enable.
- TRIG  in  1  single-cycle sweep-start pulse (from edge_detect).
- S_TDATA  in  WORD_W  stream data.
- S_TVALID  in  1  stream valid.
- S_TREADY  out  1  stream ready.
- S_TLAST  in  1  marks the final word of a pattern.
- DATA  out  SIZE  active pattern, to the generator.
- DATA_VALID  out  1  at least one pattern has been swapped in.
- TRIG_OUT  out  1  TRIG delayed one cycle, to the generator's TRIG.
- LOADED  out  1  shadow holds a complete pattern.
- UNDERRUN  out  1  one-cycle pulse: TRIG arrived with no complete shadow.
- FRAME_ERR  out  1  one-cycle pulse: TLAST position mismatch.

## Operation
- States: FILL, FULL, DISCARD. The word counter `cnt` runs 0..WORDS-1.
- FILL:
  - A beat is accepted when S_TVALID && S_TREADY.
  - The beat is written to shadow bits [cnt*WORD_W +: WORD_W], so word 0 lands in the LSBs.
  - Accepted beat with cnt = WORDS-1 and TLAST=1: go to FULL, cnt←0.
  - Accepted beat with cnt = WORDS-1 and TLAST=0: pulse FRAME_ERR, go to DISCARD, cnt←0.
  - Accepted beat with cnt < WORDS-1 and TLAST=1: pulse FRAME_ERR, discard the partial pattern, cnt←0, stay in FILL.
- DISCARD: accept and drop beats until a beat with TLAST=1, then go to FILL.
- FULL: S_TREADY=0 and LOADED=1.
- TRIG with EN=1:
  - In FULL: DATA←shadow, DATA_VALID←1, go to FILL.
  - In FILL or DISCARD: pulse UNDERRUN. DATA is unchanged (the generator repeats the previous pattern). Filling continues.
- TRIG in the same cycle as the completing beat counts as an underrun. The state still goes to FULL, and the swap happens at the next TRIG.
- S_TREADY = EN && RESETN && (state != FULL). It is combinational from registered state.
- EN low:
  - S_TREADY=0, TRIG is ignored, TRIG_OUT=0.
  - Synchronous cnt←0 and state←FILL; a partial or complete shadow is dropped.
  - DATA and DATA_VALID are held.

## Timing
- Reset (RESETN=0, asynchronous): DATA=0, DATA_VALID=0, LOADED=0, UNDERRUN=0, FRAME_ERR=0, TRIG_OUT=0, S_TREADY=0, state=FILL, cnt=0. The shadow content is don't-care.
- Swap latency: TRIG sampled at edge N gives DATA updated at edge N. DATA is visible in cycle N+1, in the same cycle TRIG_OUT is high. The generator therefore always latches the new pattern.
- UNDERRUN and FRAME_ERR are registered and high for exactly one cycle, in the cycle after the causing event.
- LOADED rises the cycle after the completing beat and falls the cycle after the swap.
- Maximum throughput is one word per cycle. A full refill takes WORDS cycles minimum, far below the sweep period.
- RESETN asserted mid-fill aborts immediately. After release, filling restarts at cnt=0.

## Structure
- Shared package `azimuth_pkg`: the WORD_W default, the state enumeration (FILL/FULL/DISCARD), and a SIZE%WORD_W==0 elaboration check helper.
- Flat module with no sub-module. edge_detect for TRIG stays outside, in the top level.
- cnt width is $clog2(WORDS). Shadow and active registers are each SIZE flops.

## Test plan
Bench uses SIZE=128, WORD_W=32 (WORDS=4).
- Reset: hold RESETN=0 while driving S_TVALID=1 → DATA=0, DATA_VALID=0, S_TREADY=0, all pulses 0.
- Normal load: send words 0x1, 0x2, 0x3, 0x4 with TLAST on the 4th, then TRIG → LOADED=1 before TRIG. One cycle after TRIG: DATA=0x00000004_00000003_00000002_00000001, DATA_VALID=1, TRIG_OUT=1 for one cycle.
- Backpressure: after the pattern is complete, hold S_TVALID=1 with a 5th word → S_TREADY=0 until TRIG. The word is accepted the cycle after the swap and lands in bits [31:0].
- Underrun: TRIG after 2 words → UNDERRUN pulses once, DATA unchanged. Words 3 and 4 still complete the pattern, and the next TRIG swaps it in.
- Framing errors:
  - TLAST on word 2 → FRAME_ERR pulse; the next word goes to bits [31:0].
  - No TLAST on word 4 → FRAME_ERR, beats dropped through the next TLAST, LOADED stays 0.
- Async reset mid-fill, and EN low mid-fill:
  - RESETN low after 3 words → outputs return to reset values without a clock edge.
  - EN low after 3 words → DATA held, cnt cleared, S_TREADY=0.
